// File: rtl/cpu_controller.sv
// cpu_controller: control FSM and instruction decoder that sequences fetch, decode and execute for the simple RISC datapath
// Ports: clk, reset_n (async active-low); ir (instruction), status {Z,V,N};
//   regfile control readnum/writenum/write/vsel; datapath loads loada/loadb/loadc/loads, asel/bsel/shift/ALUop;
//   fetch/PC control load_ir/load_pc/pc_sel; memory control addr_sel/load_addr/mem_cmd; halted.
module cpu_controller #(
  parameter logic [2:0] LR_REG = 3'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ir,
  input  logic [2:0]  status,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        load_ir,
  output logic        load_pc,
  output logic [1:0]  pc_sel,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic        halted
);
  typedef enum logic [4:0] {
    RST, IF1, IF2, UPD_PC, DECODE, WR_IMM, GET_A, GET_B, RD_B, EXEC, WR_C,
    ADDR, LD_ADDR, MEM_RD, WR_M, PASS, MEM_WR, BRANCH, WR_LR, PC_REG, HALT
  } state_t;
  state_t state, nxt, dec;
  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op;
  logic z, v, n, taken;
  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign rm  = ir[2:0];
  assign {z, v, n} = status;
  // BL shares BRANCH but is unconditional; its ir[10:8] is not a condition code
  always_comb begin
    taken = 1'b0;
    case (rn)
      3'b000: taken = 1'b1;
      3'b001: taken = z;
      3'b010: taken = !z;
      3'b011: taken = n ^ v;
      3'b100: taken = z | (n ^ v);
      default: taken = 1'b0;
    endcase
    taken = taken | (opc == 3'b010);
  end
  always_comb begin
    dec = HALT;
    case ({opc, op})
      5'b110_10: dec = WR_IMM;
      5'b110_00, 5'b101_11: dec = GET_B;
      5'b101_00, 5'b101_01, 5'b101_10, 5'b011_00, 5'b100_00: dec = GET_A;
      5'b001_00: dec = BRANCH;
      5'b010_11: dec = WR_LR;
      5'b010_00, 5'b010_10: dec = RD_B;
      default: dec = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RST;
    else state <= nxt;
  always_comb begin
    nxt = IF1;
    readnum = 3'd0;
    writenum = 3'd0;
    write = 1'b0;
    vsel = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    shift = 2'b00;
    ALUop = 2'b00;
    load_ir = 1'b0;
    load_pc = 1'b0;
    pc_sel = 2'b00;
    addr_sel = 1'b0;
    load_addr = 1'b0;
    mem_cmd = 2'b00;
    halted = 1'b0;
    case (state)
      RST: begin load_pc = 1'b1; pc_sel = 2'b11; end
      IF1: begin nxt = IF2; addr_sel = 1'b1; mem_cmd = 2'b01; end
      IF2: begin nxt = UPD_PC; addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
      UPD_PC: begin nxt = DECODE; load_pc = 1'b1; end
      DECODE: nxt = dec;
      WR_IMM: begin vsel = 2'b10; writenum = rn; write = 1'b1; end
      GET_A: begin nxt = (opc == 3'b101) ? GET_B : ADDR; readnum = rn; loada = 1'b1; end
      GET_B: begin nxt = EXEC; readnum = rm; loadb = 1'b1; end
      // CMP only updates status; MOV/MVN zero the A operand
      EXEC: begin
        nxt = (opc == 3'b101 && op == 2'b01) ? IF1 : WR_C;
        asel = (opc == 3'b110) || (op == 2'b11);
        ALUop = (opc == 3'b110) ? 2'b00 : op;
        shift = (opc == 3'b101 && op == 2'b01) ? 2'b00 : ir[4:3];
        loads = (opc == 3'b101 && op == 2'b01);
        loadc = !(opc == 3'b101 && op == 2'b01);
      end
      WR_C: begin writenum = rd; write = 1'b1; end
      ADDR: begin nxt = LD_ADDR; bsel = 1'b1; loadc = 1'b1; end
      LD_ADDR: begin nxt = (opc == 3'b011) ? MEM_RD : RD_B; load_addr = 1'b1; end
      MEM_RD: begin nxt = WR_M; mem_cmd = 2'b01; end
      WR_M: begin mem_cmd = 2'b01; vsel = 2'b01; writenum = rd; write = 1'b1; end
      RD_B: begin nxt = PASS; readnum = rd; loadb = 1'b1; end
      PASS: begin
        nxt = (opc == 3'b100) ? MEM_WR : (op == 2'b10) ? WR_LR : PC_REG;
        asel = 1'b1;
        loadc = 1'b1;
      end
      MEM_WR: mem_cmd = 2'b10;
      BRANCH: begin load_pc = taken; pc_sel = taken ? 2'b01 : 2'b00; end
      WR_LR: begin nxt = (op == 2'b11) ? BRANCH : PC_REG; vsel = 2'b11; writenum = LR_REG; write = 1'b1; end
      PC_REG: begin load_pc = 1'b1; pc_sel = 2'b10; end
      HALT: begin nxt = HALT; halted = 1'b1; end
      default: nxt = RST;
    endcase
  end
endmodule
